// File: rtl/hcsr04_pkg.sv
// Shared definitions for the HC-SR04 echo emulator: state encoding, cycle-count
// formulas and jitter LFSR constants.
package hcsr04_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG_HIGH,
    ST_BURST,
    ST_ECHO,
    ST_HOLDOFF
  } state_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;  // x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  function automatic logic [31:0] cyc_per_us(input logic [31:0] clk_hz);
    return clk_hz / 32'd1_000_000;
  endfunction

  function automatic logic [31:0] us_to_cyc(input logic [31:0] us, input logic [31:0] clk_hz);
    return us * cyc_per_us(clk_hz);
  endfunction

  function automatic logic [31:0] timeout_cyc(input logic [31:0] timeout_us, input logic [31:0] clk_hz);
    return us_to_cyc(timeout_us, clk_hz);
  endfunction

  function automatic logic [31:0] holdoff_cyc(input logic [31:0] holdoff_us, input logic [31:0] clk_hz);
    return us_to_cyc(holdoff_us, clk_hz);
  endfunction

  // Echo width in cycles; out-of-range distances report "no object".
  function automatic logic [31:0] echo_cyc(input logic [31:0] dist_cm, input logic [31:0] us_per_cm,
                                           input logic [31:0] max_cm, input logic [31:0] timeout_us,
                                           input logic [31:0] clk_hz);
    if (dist_cm == 32'd0 || dist_cm > max_cm)
      return timeout_cyc(timeout_us, clk_hz);
    return dist_cm * us_per_cm * cyc_per_us(clk_hz);
  endfunction

  function automatic logic [31:0] max32(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous single-bit or bus inputs.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 responder: validates the trigger, waits the burst delay, returns a
// distance-coded echo, then holds off. Optional jitter via `ECHO_JITTER_EN.
module hcsr04_echo_emulator
  import hcsr04_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
  parameter int unsigned TRIG_MIN_US    = 10,
  parameter int unsigned BURST_DELAY_US = 200,
  parameter int unsigned US_PER_CM      = 58,
  parameter int unsigned MAX_DIST_CM    = 400,
  parameter int unsigned TIMEOUT_US     = 38000,
  parameter int unsigned HOLDOFF_US     = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger_i,
  input  logic [8:0] distance_cm_i,
  output logic       echo_o,
  output logic       busy_o,
  output logic       meas_done_o,
  output logic       short_trig_o
);

  localparam logic [31:0] CYC       = cyc_per_us(CLK_FREQ_HZ);
  localparam logic [31:0] TRIG_CYC  = us_to_cyc(TRIG_MIN_US, CLK_FREQ_HZ);
  localparam logic [31:0] BURST_CYC = us_to_cyc(BURST_DELAY_US, CLK_FREQ_HZ);
  localparam logic [31:0] HOLD_CYC  = holdoff_cyc(HOLDOFF_US, CLK_FREQ_HZ);
  localparam logic [31:0] TMO_CYC   = timeout_cyc(TIMEOUT_US, CLK_FREQ_HZ);
  localparam logic [31:0] DIST_CYC  = MAX_DIST_CM * US_PER_CM * CYC;
  localparam logic [31:0] JIT_CYC   = 32'd7 * CYC;
  localparam logic [31:0] MAX_CYC   = max32(max32(TMO_CYC, DIST_CYC) + JIT_CYC,
                                            max32(HOLD_CYC, max32(BURST_CYC, TRIG_CYC)));
  localparam int unsigned CNT_W     = $clog2(MAX_CYC + 32'd1);

  localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_CYC - 32'd1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_CYC - 32'd1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 32'd1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] echo_last_q;
  logic [8:0]       dist_q;
  logic             armed_q, armed_d;
  logic             meas_done_q, meas_done_d;
  logic             short_q, short_d;
  logic             load_dist, load_len;
  logic             trig_s;
  logic [31:0]      jitter;
  logic [31:0]      w_full;

  sync_2ff #(.WIDTH(1)) u_trig_sync (
    .clk (clk),
    .rst (rst),
    .d   (trigger_i),
    .q   (trig_s)
  );

`ifdef ECHO_JITTER_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  assign jitter = 32'(lfsr_q[2:0]) * CYC;
`else
  assign jitter = '0;
`endif

  assign w_full = echo_cyc(32'(dist_q), US_PER_CM, MAX_DIST_CM, TIMEOUT_US, CLK_FREQ_HZ) + jitter;

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    meas_done_d = 1'b0;
    short_d     = 1'b0;
    load_dist   = 1'b0;
    load_len    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A trigger still high when holdoff ended must drop before it counts.
        if (!trig_s) armed_d = 1'b1;
        if (trig_s && armed_q) state_d = ST_TRIG_HIGH;
      end
      ST_TRIG_HIGH: begin
        if (!trig_s) begin
          if (cnt_q >= TRIG_LAST) begin
            state_d   = ST_BURST;
            load_dist = 1'b1;
          end else begin
            state_d = ST_IDLE;
            short_d = 1'b1;
          end
        end
      end
      ST_BURST: begin
        if (cnt_q == BURST_LAST) begin
          state_d  = ST_ECHO;
          load_len = 1'b1;
        end
      end
      ST_ECHO: begin
        if (cnt_q == echo_last_q) begin
          state_d     = ST_HOLDOFF;
          meas_done_d = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_IDLE;
          armed_d = !trig_s;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != '1)    cnt_d = cnt_q + 1'b1;
    else                     cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      echo_last_q <= '0;
      dist_q      <= '0;
      armed_q     <= 1'b1;
      meas_done_q <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      meas_done_q <= meas_done_d;
      short_q     <= short_d;
      if (load_dist) dist_q      <= distance_cm_i;
      if (load_len)  echo_last_q <= CNT_W'(w_full - 32'd1);
    end
  end

  assign echo_o       = (state_q == ST_ECHO);
  assign busy_o       = (state_q != ST_IDLE);
  assign meas_done_o  = meas_done_q;
  assign short_trig_o = short_q;

endmodule
